// File: rtl/ps2_scan_display_if.sv
// Pin-level bundle of the PS/2 keyboard monitor: PS/2 lines in, display and key-event lines out.
interface ps2_scan_display_if #(
   parameter int NUM_DIGITS = 4
);
   logic                  ps2d;
   logic                  ps2c;
   logic [NUM_DIGITS-1:0] an;
   logic [7:0]            sseg;
   logic                  key_valid;
   logic [7:0]            key_code;
   logic                  key_ext;
   logic                  key_break;
   logic                  parity_err;

   modport master (
      output ps2d, ps2c,
      input  an, sseg, key_valid, key_code, key_ext, key_break, parity_err
   );

   modport slave (
      input  ps2d, ps2c,
      output an, sseg, key_valid, key_code, key_ext, key_break, parity_err
   );
endinterface

// File: rtl/ps2_scan_display.sv
// PS/2 keyboard monitor: frame receiver, E0/F0 prefix decoder, key-code history
// and a time-multiplexed hex display of that history.
//
// receiver   | meaning
// RX_IDLE    | waiting for a start bit (fall tick with ps2d low)
// RX_DATA    | shifting 8 data bits, parity and stop, one per fall tick
// RX_CHECK   | one cycle: flag byte_done or parity_err, then back to idle
//
// decoder    | meaning
// DC_BASE    | no prefix seen
// DC_EXT     | E0 seen
// DC_BRK     | F0 seen
// DC_EXTBRK  | E0 and F0 seen
module ps2_scan_display #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_BITS = 16,
   parameter int FILTER_LEN   = 8,
   parameter int TIMEOUT_CYC  = 100000,
   parameter int SHOW_BREAK   = 0
) (
   input logic clk,
   input logic reset,
   ps2_scan_display_if.slave bus
);

   localparam int HIST = NUM_DIGITS / 2;
   localparam int PW   = $clog2(NUM_DIGITS);
   localparam int TW   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_CHECK} rx_state_t;
   typedef enum logic [1:0] {DC_BASE, DC_EXT, DC_BRK, DC_EXTBRK} dc_state_t;

   logic [FILTER_LEN-1:0] filt_sr;
   logic [FILTER_LEN-1:0] filt_nxt;
   logic                  ps2c_f;
   logic                  ps2c_f_d;
   logic                  fall_tick;
   logic                  d_meta;
   logic                  d_sync;

   rx_state_t             rx_state;
   rx_state_t             rx_next;
   logic [3:0]            bit_cnt;
   logic [9:0]            frame_sr;
   logic [TW-1:0]         to_cnt;
   logic                  rx_timeout;
   logic                  frame_ok;
   logic                  byte_done;
   logic                  rx_perr;
   logic [7:0]            rx_byte;

   dc_state_t             dc_state;
   dc_state_t             dc_next;
   logic                  emit;
   logic                  emit_ext;
   logic                  emit_brk;
   logic                  key_valid_q;
   logic [7:0]            key_code_q;
   logic                  key_ext_q;
   logic                  key_break_q;

   logic [HIST-1:0][8:0]  hist;
   logic [REFRESH_BITS-1:0] presc;
   logic [PW-1:0]         dig_ptr;
   logic [8:0]            sel_entry;
   logic [3:0]            nibble;
   logic                  dp_n;
   logic [NUM_DIGITS-1:0] an_q;
   logic [7:0]            sseg_q;

   // Filtered clock is decided from the shift register including the current sample,
   // so it changes on the FILTER_LEN-th consistent sample.
   assign filt_nxt  = {filt_sr[FILTER_LEN-2:0], bus.ps2c};
   assign fall_tick = ps2c_f_d & ~ps2c_f;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_sr  <= '1;
         ps2c_f   <= 1'b1;
         ps2c_f_d <= 1'b1;
         d_meta   <= 1'b1;
         d_sync   <= 1'b1;
      end else begin
         filt_sr  <= filt_nxt;
         if (&filt_nxt)
            ps2c_f <= 1'b1;
         else if (~|filt_nxt)
            ps2c_f <= 1'b0;
         ps2c_f_d <= ps2c_f;
         d_meta   <= bus.ps2d;
         d_sync   <= d_meta;
      end
   end

   assign rx_timeout = (rx_state == RX_DATA) && !fall_tick && (to_cnt == '0);
   assign frame_ok   = frame_sr[9] & (^frame_sr[8:0]);
   assign byte_done  = (rx_state == RX_CHECK) && frame_ok;
   assign rx_perr    = (rx_state == RX_CHECK) && !frame_ok;
   assign rx_byte    = frame_sr[7:0];

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (fall_tick && !d_sync) rx_next = RX_DATA;
         RX_DATA: begin
            if (rx_timeout)
               rx_next = RX_IDLE;
            else if (fall_tick && bit_cnt == 4'd9)
               rx_next = RX_CHECK;
         end
         RX_CHECK: rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state <= RX_IDLE;
         bit_cnt  <= '0;
         frame_sr <= '0;
         to_cnt   <= '0;
      end else begin
         rx_state <= rx_next;
         if (rx_state == RX_IDLE && fall_tick && !d_sync)
            bit_cnt <= '0;
         else if (rx_state == RX_DATA && fall_tick) begin
            bit_cnt  <= bit_cnt + 4'd1;
            frame_sr <= {d_sync, frame_sr[9:1]};
         end
         if (fall_tick)
            to_cnt <= TW'(TIMEOUT_CYC);
         else if (rx_state == RX_DATA && to_cnt != '0)
            to_cnt <= to_cnt - TW'(1);
      end
   end

   assign emit_ext = (dc_state == DC_EXT) || (dc_state == DC_EXTBRK);
   assign emit_brk = (dc_state == DC_BRK) || (dc_state == DC_EXTBRK);

   always_comb begin
      dc_next = dc_state;
      emit    = 1'b0;
      if (rx_perr || rx_timeout)
         dc_next = DC_BASE;
      else if (byte_done) begin
         if (rx_byte == 8'hE0) begin
            if (dc_state == DC_BASE)     dc_next = DC_EXT;
            else if (dc_state == DC_BRK) dc_next = DC_EXTBRK;
         end else if (rx_byte == 8'hF0) begin
            if (dc_state == DC_BASE)     dc_next = DC_BRK;
            else if (dc_state == DC_EXT) dc_next = DC_EXTBRK;
         end else begin
            emit    = 1'b1;
            dc_next = DC_BASE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dc_state    <= DC_BASE;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         key_ext_q   <= 1'b0;
         key_break_q <= 1'b0;
         hist        <= '0;
      end else begin
         dc_state    <= dc_next;
         key_valid_q <= emit;
         if (emit) begin
            key_code_q  <= rx_byte;
            key_ext_q   <= emit_ext;
            key_break_q <= emit_brk;
            if (SHOW_BREAK != 0 || !emit_brk) begin
               for (int k = HIST - 1; k > 0; k--)
                  hist[k] <= hist[k-1];
               hist[0] <= {emit_ext, rx_byte};
            end
         end
      end
   end

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'b1000000;
         4'h1: hex_glyph = 7'b1111001;
         4'h2: hex_glyph = 7'b0100100;
         4'h3: hex_glyph = 7'b0110000;
         4'h4: hex_glyph = 7'b0011001;
         4'h5: hex_glyph = 7'b0010010;
         4'h6: hex_glyph = 7'b0000010;
         4'h7: hex_glyph = 7'b1111000;
         4'h8: hex_glyph = 7'b0000000;
         4'h9: hex_glyph = 7'b0010000;
         4'hA: hex_glyph = 7'b0001000;
         4'hB: hex_glyph = 7'b0000011;
         4'hC: hex_glyph = 7'b1000110;
         4'hD: hex_glyph = 7'b0100001;
         4'hE: hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      sel_entry = '0;
      for (int k = 0; k < HIST; k++)
         if (int'(dig_ptr) / 2 == k)
            sel_entry = hist[k];
      nibble = dig_ptr[0] ? sel_entry[7:4] : sel_entry[3:0];
      dp_n   = ~(sel_entry[8] & ~dig_ptr[0]);
   end

   // an/sseg are registered together so the enable and glyph always change on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc   <= '0;
         dig_ptr <= '0;
         an_q    <= '1;
         sseg_q  <= '1;
      end else begin
         presc <= presc + REFRESH_BITS'(1);
         if (&presc)
            dig_ptr <= (dig_ptr == PW'(NUM_DIGITS - 1)) ? '0 : dig_ptr + PW'(1);
         an_q   <= ~(NUM_DIGITS'(1) << dig_ptr);
         sseg_q <= {dp_n, hex_glyph(nibble)};
      end
   end

   assign bus.an         = an_q;
   assign bus.sseg       = sseg_q;
   assign bus.key_valid  = key_valid_q;
   assign bus.key_code   = key_code_q;
   assign bus.key_ext    = key_ext_q;
   assign bus.key_break  = key_break_q;
   assign bus.parity_err = rx_perr;

endmodule

// File: tb/tb_ps2_scan_display.sv
// Directed bench for ps2_scan_display: two instances (make-only and make+break history)
// share one PS/2 stimulus stream.
module tb_ps2_scan_display;

   localparam int ND = 4;
   localparam int RB = 4;
   localparam int FL = 4;
   localparam int TO = 200;
   localparam int HP = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ps2c_tb = 1'b1;
   logic ps2d_tb = 1'b1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rel_cnt = 0;
   int kv0 = 0, kv1 = 0, pe0 = 0, pe1 = 0;
   int kv0_cyc = 0, pe0_cyc = 0;
   int an_bad = 0;
   int t_prev = 0, t_last = 0;
   int last_fall_c0 = 0;
   logic [ND-1:0] an0_prev = '1;

   ps2_scan_display_if #(.NUM_DIGITS(ND)) bus0 ();
   ps2_scan_display_if #(.NUM_DIGITS(ND)) bus1 ();

   assign bus0.ps2c = ps2c_tb;
   assign bus0.ps2d = ps2d_tb;
   assign bus1.ps2c = ps2c_tb;
   assign bus1.ps2d = ps2d_tb;

   ps2_scan_display #(.NUM_DIGITS(ND), .REFRESH_BITS(RB), .FILTER_LEN(FL),
                      .TIMEOUT_CYC(TO), .SHOW_BREAK(0)) dut0 (
      .clk(clk), .reset(rst_n), .bus(bus0));

   ps2_scan_display #(.NUM_DIGITS(ND), .REFRESH_BITS(RB), .FILTER_LEN(FL),
                      .TIMEOUT_CYC(TO), .SHOW_BREAK(1)) dut1 (
      .clk(clk), .reset(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rel_cnt <= rst_n ? rel_cnt + 1 : 0;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus0.key_valid) begin
            kv0     <= kv0 + 1;
            kv0_cyc <= cyc;
         end
         if (bus1.key_valid) kv1 <= kv1 + 1;
         if (bus0.parity_err) begin
            pe0     <= pe0 + 1;
            pe0_cyc <= cyc;
         end
         if (bus1.parity_err) pe1 <= pe1 + 1;
         if (rel_cnt >= 1 && (!$onehot(~bus0.an) || !$onehot(~bus1.an)))
            an_bad <= an_bad + 1;
         if (bus0.an == 4'b1110 && an0_prev != 4'b1110) begin
            t_prev <= t_last;
            t_last <= cyc;
         end
         an0_prev <= bus0.an;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2d_tb = b;
      wait_clk(HP / 2);
      ps2c_tb = 1'b0;
      last_fall_c0 = cyc;
      wait_clk(HP);
      ps2c_tb = 1'b1;
      wait_clk(HP / 2);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ flip_par);
      send_bit(stop_bit);
      ps2d_tb = 1'b1;
      wait_clk(HP);
   endtask

   task automatic digit_check(input string tag, input int which, input int d, input logic [7:0] exp);
      logic [ND-1:0] tgt;
      logic [ND-1:0] a;
      logic [7:0]    seg;
      tgt = ~(ND'(1) << d);
      seg = 'x;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         a = (which != 0) ? bus1.an : bus0.an;
         if (a == tgt) begin
            seg = (which != 0) ? bus1.sseg : bus0.sseg;
            break;
         end
      end
      check(tag, 32'(seg), 32'(exp));
   endtask

   initial begin
      wait_clk(3);
      check("reset_an", 32'(bus0.an), 32'hF);
      check("reset_sseg", 32'(bus0.sseg), 32'hFF);
      check("reset_kv", 32'(bus0.key_valid), 32'h0);
      check("reset_code", 32'(bus0.key_code), 32'h0);
      check("reset_perr", 32'(bus0.parity_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_clk(1);
      check("first_an", 32'(bus0.an), 32'hE);
      check("first_sseg", 32'(bus0.sseg), 32'hC0);
      wait_clk(HP);

      // plain make code
      send_frame(8'h1C, 1'b0, 1'b1);
      check("1c_count", 32'(kv0), 32'd1);
      check("1c_latency", 32'(kv0_cyc - last_fall_c0), 32'(FL + 2));
      check("1c_code", 32'(bus0.key_code), 32'h1C);
      check("1c_ext", 32'(bus0.key_ext), 32'h0);
      check("1c_brk", 32'(bus0.key_break), 32'h0);
      digit_check("1c_d0", 0, 0, 8'hC6);
      digit_check("1c_d1", 0, 1, 8'hF9);

      // break code: only the SHOW_BREAK instance records it
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("brk_count", 32'(kv0), 32'd2);
      check("brk_count_sb1", 32'(kv1), 32'd2);
      check("brk_code", 32'(bus0.key_code), 32'h1C);
      check("brk_flag", 32'(bus0.key_break), 32'h1);
      digit_check("brk_d2_sb0", 0, 2, 8'hC0);
      digit_check("brk_d2_sb1", 1, 2, 8'hC6);
      digit_check("brk_d0_sb1", 1, 0, 8'hC6);

      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      check("extbrk_count", 32'(kv0), 32'd3);
      check("extbrk_code", 32'(bus0.key_code), 32'h75);
      check("extbrk_ext", 32'(bus0.key_ext), 32'h1);
      check("extbrk_brk", 32'(bus0.key_break), 32'h1);
      digit_check("extbrk_d0_sb0", 0, 0, 8'hC6);
      digit_check("extbrk_d0_sb1", 1, 0, 8'h12);

      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      check("ext_count", 32'(kv0), 32'd4);
      check("ext_ext", 32'(bus0.key_ext), 32'h1);
      check("ext_brk", 32'(bus0.key_break), 32'h0);
      digit_check("ext_d0_dp", 0, 0, 8'h12);
      digit_check("ext_d1", 0, 1, 8'hF8);
      digit_check("ext_d2", 0, 2, 8'hC6);

      // framing errors; the parity error must also clear the pending F0
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b1, 1'b1);
      check("par_pe", 32'(pe0), 32'd1);
      check("par_latency", 32'(pe0_cyc - last_fall_c0), 32'(FL + 1));
      check("par_no_kv", 32'(kv0), 32'd4);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("stop_pe", 32'(pe0), 32'd2);
      check("stop_pe_sb1", 32'(pe1), 32'd2);
      check("stop_no_kv", 32'(kv0), 32'd4);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("after_err_count", 32'(kv0), 32'd5);
      check("after_err_brk", 32'(bus0.key_break), 32'h0);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("f0_1c_count", 32'(kv0), 32'd6);
      check("f0_1c_brk", 32'(bus0.key_break), 32'h1);
      check("f0_1c_code", 32'(bus0.key_code), 32'h1C);

      // partial frame abandoned by timeout
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      ps2d_tb = 1'b1;
      wait_clk(TO + 10);
      check("partial_no_kv", 32'(kv0), 32'd6);
      check("partial_no_pe", 32'(pe0), 32'd2);
      send_frame(8'h29, 1'b0, 1'b1);
      check("to_count", 32'(kv0), 32'd7);
      check("to_code", 32'(bus0.key_code), 32'h29);
      digit_check("hist_d0", 0, 0, 8'h90);
      digit_check("hist_d1", 0, 1, 8'hA4);
      digit_check("hist_d2", 0, 2, 8'hC6);
      digit_check("hist_d3", 0, 3, 8'hF9);

      // glitch one sample short of the filter length, with ps2d low as if a start bit
      ps2d_tb = 1'b0;
      wait_clk(HP / 2);
      ps2c_tb = 1'b0;
      wait_clk(FL - 1);
      ps2c_tb = 1'b1;
      wait_clk(HP);
      ps2d_tb = 1'b1;
      wait_clk(HP);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("glitch_count", 32'(kv0), 32'd8);
      check("glitch_code", 32'(bus0.key_code), 32'h1C);
      check("glitch_no_pe", 32'(pe0), 32'd2);

      check("an_onehot", 32'(an_bad), 32'd0);
      check("digit_period", 32'(t_last - t_prev), 32'(ND * (1 << RB)));

      // reset in the middle of a frame
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst_n = 1'b0;
      wait_clk(3);
      check("midrst_an", 32'(bus0.an), 32'hF);
      check("midrst_code", 32'(bus0.key_code), 32'h0);
      ps2d_tb = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      wait_clk(HP);
      check("midrst_no_kv", 32'(kv0), 32'd8);
      send_frame(8'h5A, 1'b0, 1'b1);
      check("midrst_count", 32'(kv0), 32'd9);
      check("midrst_new_code", 32'(bus0.key_code), 32'h5A);
      check("midrst_pe", 32'(pe0), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
